// File: rtl/fetch_decode_queue.sv
// Purpose: LC-3b fetch->decode instruction queue holding {pc, instr}; exposes opcode and raw imm bits of the head.
// Latency: 1 cycle push-to-head; 0 cycles with FDQ_BYPASS_EN when empty (fall-through).
// Backpressure: if_ready = !rst & !full, independent of id_ready; full+pop frees a slot the next cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop all entries (redirect)
//   if_valid/if_ready         fetch handshake, if_instr/if_pc payload
//   id_valid/id_ready         decode handshake, id_instr/id_pc head payload
//   id_opcode, id_imm_bits    wiring from id_instr for the sign-extension unit
//   id_count                  occupancy 0..DEPTH
// Optional feature macro: FDQ_BYPASS_EN (zero-latency fall-through when empty).
module fetch_decode_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [15:0]                  if_instr,
    input  logic [15:0]                  if_pc,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [15:0]                  id_instr,
    output logic [15:0]                  id_pc,
    output logic [3:0]                   id_opcode,
    output logic [15:0]                  id_imm_bits,
    output logic [$clog2(DEPTH):0]       id_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // Each entry is {pc, instr}.
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [31:0]      head;
    logic             byp_act;
    logic             byp_take;
    logic             push;
    logic             pop;
    logic             push_wr;
    logic             pop_rd;

    always_comb begin
        if_ready = !rst && (count_q != FULL_CNT);
`ifdef FDQ_BYPASS_EN
        // Empty queue: the incoming word is presented to decode in the same cycle.
        byp_act  = (count_q == '0) && if_valid && !flush && !rst;
        head     = byp_act ? {if_pc, if_instr} : mem_q[rd_ptr_q];
`else
        byp_act  = 1'b0;
        head     = mem_q[rd_ptr_q];
`endif
        id_valid = byp_act || (count_q != '0);
        push     = if_valid && if_ready;
        pop      = id_valid && id_ready;
        // A fall-through word taken by decode never touches storage.
        byp_take = byp_act && id_ready;
        push_wr  = push && !byp_take && !flush;
        pop_rd   = pop && !byp_take && !flush;
    end

    assign id_instr    = head[15:0];
    assign id_pc       = head[31:16];
    assign id_opcode   = id_instr[15:12];
    assign id_imm_bits = {5'b0, id_instr[10:0]};
    assign id_count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_wr) begin
                mem_d[wr_ptr_q] = {if_pc, if_instr};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_wr && !pop_rd) begin
                count_d = count_q + 1'b1;
            end else if (pop_rd && !push_wr) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Occupancy stays within 0..DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= FULL_CNT);
            assert (!(pop_rd && (count_q == '0)));
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [15:0] if_instr = '0;
    logic [15:0] if_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [3:0]  id_opcode;
    logic [15:0] id_imm_bits;
    logic [2:0]  id_count;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of {pc, instr}.
    logic [31:0] mq[$];
    bit          cleared = 1'b1;

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_imm_bits(id_imm_bits), .id_count(id_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model at the edge.
    task automatic step(input bit r, input bit fl, input bit v, input logic [15:0] ins,
                        input logic [15:0] pc, input bit rdy);
        bit          exp_rdy, exp_vld, byp, do_push, do_pop;
        logic [31:0] w;
        @(negedge clk);
        rst = r; flush = fl; if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy;
        #1;
        exp_rdy = !r && (mq.size() != DEPTH);
        byp = 1'b0;
`ifdef FDQ_BYPASS_EN
        byp = (mq.size() == 0) && v && !fl && !r;
`endif
        exp_vld = (mq.size() != 0) || byp;
        w = byp ? {pc, ins} : ((mq.size() != 0) ? mq[0] : 32'h0);
        chk("if_ready", {31'b0, if_ready}, {31'b0, exp_rdy});
        chk("id_valid", {31'b0, id_valid}, {31'b0, exp_vld});
        chk("id_count", {29'b0, id_count}, mq.size());
        if (exp_vld) begin
            chk("id_instr", {16'b0, id_instr}, {16'b0, w[15:0]});
            chk("id_pc", {16'b0, id_pc}, {16'b0, w[31:16]});
            chk("id_opcode", {28'b0, id_opcode}, {28'b0, w[15:12]});
            chk("id_imm_bits", {16'b0, id_imm_bits}, {21'b0, w[10:0]});
        end else if (cleared) begin
            chk("id_instr_rst", {16'b0, id_instr}, 32'h0);
            chk("id_pc_rst", {16'b0, id_pc}, 32'h0);
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            cleared = 1'b1;
        end else if (fl) begin
            mq.delete();
        end else begin
            do_push = v && exp_rdy;
            do_pop  = exp_vld && rdy;
            if (!(byp && rdy)) begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back({pc, ins});
                    cleared = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, rdy);
    endtask

    logic [15:0] words [4];

    initial begin
        words[0] = 16'h0A05; words[1] = 16'h2C41; words[2] = 16'h6283; words[3] = 16'hE1FE;

        // Reset and post-reset state.
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(1'b0);

        // Single push, visible next cycle, then popped.
        step(1'b0, 1'b0, 1'b1, 16'h1021, 16'h3000, 1'b0);
        idle(1'b0);
        chk("first_opcode", {28'b0, id_opcode}, 32'h1);
        chk("first_pc", {16'b0, id_pc}, 32'h3000);
        idle(1'b1);

        // Fill to full, then drain in order.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, words[i], 16'h3000 + 16'(2*i), 1'b0);
        idle(1'b0);
        chk("full_not_ready", {31'b0, if_ready}, 32'h0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Full queue with simultaneous push attempt and pop.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, words[i], 16'h4000 + 16'(2*i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h4100, 1'b1);
        idle(1'b0);
        chk("full_pop_count", {29'b0, id_count}, 32'd3);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Ten words streamed with decode always ready.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'h5000 + 16'(i), 16'h3100 + 16'(2*i), 1'b1);
            chk("stream_cnt_le1", {31'b0, id_count <= 3'd1}, 32'h1);
        end
        idle(1'b1);

        // Flush with three entries and a push in the same cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, words[i], 16'h3200 + 16'(2*i), 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h7777, 16'h3300, 1'b1);
        idle(1'b0);
        chk("flush_count", {29'b0, id_count}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h9ABC, 16'h3400, 1'b0);
        idle(1'b0);
        chk("after_flush_head", {16'b0, id_instr}, 32'h9ABC);
        idle(1'b1);

`ifdef FDQ_BYPASS_EN
        // Zero-latency fall-through consumed in the same cycle.
        step(1'b0, 1'b0, 1'b1, 16'h0E05, 16'h3500, 1'b1);
        idle(1'b0);
        chk("bypass_count", {29'b0, id_count}, 32'h0);
`endif

        // Reset mid-stream with two entries.
        step(1'b0, 1'b0, 1'b1, 16'h1111, 16'h3600, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h2222, 16'h3602, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h3333, 16'h3604, 1'b0);
        idle(1'b0);
        chk("midrst_instr", {16'b0, id_instr}, 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                 1'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
